// File: rtl/chasy_pkg.sv
// Shared types and helpers for the clock front-panel logic.
// Mode numbering, press-classifier states and counter sizing.
package chasy_pkg;

  typedef enum int {
    MODE_CLOCK     = 0,
    MODE_SETUP     = 1,
    MODE_TIMER     = 2,
    MODE_STOPWATCH = 3
  } mode_e;

  typedef enum logic [1:0] {
    CL_IDLE,
    CL_PRESSED,
    CL_HELD,
    CL_SUPPRESS
  } cl_state_e;

  // Cycles per millisecond, never below one.
  function automatic int MS_DIV(int hz);
    return (hz < 2000) ? 1 : hz / 1000;
  endfunction

  // Bits needed to hold 0..max.
  function automatic int cnt_w(int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mode_ctrl_if.sv
// Button/mode bundle between debouncers, mode_ctrl and function blocks.
// master drives button levels, slave produces mode and events.
interface mode_ctrl_if #(
  parameter int N_BUTTONS = 4,
  parameter int MW        = 2
);

  logic [N_BUTTONS-1:0] btn_level;
  logic                 hold_mode;
  logic [MW-1:0]        mode;
  logic                 mode_changed;
  logic [N_BUTTONS-1:0] short_press;
  logic [N_BUTTONS-1:0] long_press;
  logic [N_BUTTONS-1:0] repeat_press;

  modport master (
    output btn_level,
    output hold_mode,
    input  mode,
    input  mode_changed,
    input  short_press,
    input  long_press,
    input  repeat_press
  );

  modport slave (
    input  btn_level,
    input  hold_mode,
    output mode,
    output mode_changed,
    output short_press,
    output long_press,
    output repeat_press
  );

endinterface

// File: rtl/press_classifier.sv
// Per-button press classifier: short, long and auto-repeat events.
// Outputs are next-cycle strobes; the parent registers them.
module press_classifier
  import chasy_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic level,
  input  logic suppress,
  output logic short_nxt,
  output logic long_nxt,
  output logic rep_nxt
);

  localparam int HW = cnt_w(LONG_MS);
  localparam int RW = cnt_w(REPEAT_MS);
  localparam logic [HW-1:0] HLAST = HW'(LONG_MS - 1);
  localparam logic [RW-1:0] RLAST =
    RW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
  localparam bit REP_EN = (REPEAT_MS > 0);

  cl_state_e     state;
  logic          prev;
  logic [HW-1:0] hcnt;
  logic [RW-1:0] rcnt;
  logic          rise;
  logic          fall;

  // Edge detect and terminal-count decode; release beats terminal count.
  always_comb begin
    rise      = level & ~prev;
    fall      = ~level & prev;
    short_nxt = (state == CL_PRESSED) && fall;
    long_nxt  = (state == CL_PRESSED) && !fall && tick
                && (hcnt == HLAST);
    rep_nxt   = REP_EN && (state == CL_HELD) && !fall && tick
                && (rcnt == RLAST);
  end

  // State machine with saturating hold and repeat counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CL_IDLE;
      prev  <= 1'b1;
      hcnt  <= '0;
      rcnt  <= '0;
    end else begin
      prev <= level;
      if (suppress &&
          (state == CL_PRESSED || state == CL_HELD)) begin
        state <= CL_SUPPRESS;
      end else begin
        unique case (state)
          CL_IDLE: begin
            if (rise) begin
              state <= CL_PRESSED;
              hcnt  <= '0;
            end
          end
          CL_PRESSED: begin
            if (fall) begin
              state <= CL_IDLE;
            end else if (long_nxt) begin
              state <= CL_HELD;
              rcnt  <= '0;
            end else if (tick && hcnt != HLAST) begin
              hcnt <= hcnt + 1'b1;
            end
          end
          CL_HELD: begin
            if (fall) begin
              state <= CL_IDLE;
            end else if (rep_nxt) begin
              rcnt <= '0;
            end else if (tick && rcnt != RLAST) begin
              rcnt <= rcnt + 1'b1;
            end
          end
          CL_SUPPRESS: begin
            if (!level) state <= CL_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// Mode controller: ms prescaler, mode register, idle return.
// Button 0 steps/homes the mode; other buttons pass through as events.
module mode_ctrl
  import chasy_pkg::*;
#(
  parameter int N_MODES         = 4,
  parameter int N_BUTTONS       = 4,
  parameter int CLK_HZ          = 50_000_000,
  parameter int LONG_PRESS_MS   = 1000,
  parameter int REPEAT_MS       = 200,
  parameter int IDLE_TIMEOUT_MS = 30000
) (
  input  logic     clock,
  input  logic     reset,
  mode_ctrl_if.slave bus
);

  localparam int MW  = $clog2(N_MODES);
  localparam int DIV = MS_DIV(CLK_HZ);
  localparam int PW  = cnt_w(DIV - 1);
  localparam int IW  = cnt_w(IDLE_TIMEOUT_MS);
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [IW-1:0] ILAST =
    IW'((IDLE_TIMEOUT_MS > 0) ? IDLE_TIMEOUT_MS - 1 : 0);
  localparam bit IDLE_EN = (IDLE_TIMEOUT_MS > 0);
  localparam logic [MW-1:0] MLAST = MW'(N_MODES - 1);
  localparam logic [MW-1:0] HOME  = MW'(MODE_CLOCK);

  logic [PW-1:0]        pcnt;
  logic                 tick;
  logic [IW-1:0]        icnt;
  logic [N_BUTTONS-1:0] lvl_prev;
  logic [MW-1:0]        mode_q;
  logic [MW-1:0]        mode_nxt;
  logic                 mchg_q;
  logic                 chg;
  logic                 any_edge;
  logic                 btn_chg;
  logic                 idle_clr;
  logic                 idle_to;
  logic [N_BUTTONS-1:0] sn;
  logic [N_BUTTONS-1:0] ln;
  logic [N_BUTTONS-1:0] rn;
  logic [N_BUTTONS-1:0] supp;
  logic [N_BUTTONS-1:0] sp_q;
  logic [N_BUTTONS-1:0] lp_q;
  logic [N_BUTTONS-1:0] rp_q;

  assign tick = (pcnt == PLAST);

  // Millisecond prescaler; a divide-by-one stays at zero and ticks always.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (pcnt == PLAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    press_classifier #(
      .LONG_MS   (LONG_PRESS_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_pc (
      .clock     (clock),
      .reset     (reset),
      .tick      (tick),
      .level     (bus.btn_level[i]),
      .suppress  (supp[i]),
      .short_nxt (sn[i]),
      .long_nxt  (ln[i]),
      .rep_nxt   (rn[i])
    );
  end

  // Next mode; short, long and idle causes are mutually exclusive.
  always_comb begin
    any_edge = |(bus.btn_level ^ lvl_prev);
    btn_chg  = sn[0] | (ln[0] & (mode_q != HOME));
    idle_clr = any_edge | bus.hold_mode | btn_chg
               | (mode_q == HOME);
    idle_to  = IDLE_EN & ~idle_clr & tick & (icnt == ILAST);
    mode_nxt = mode_q;
    unique case (1'b1)
      sn[0]:   mode_nxt = (mode_q == MLAST) ? HOME
                                            : mode_q + 1'b1;
      ln[0]:   mode_nxt = HOME;
      idle_to: mode_nxt = HOME;
      default: ;
    endcase
    chg  = (mode_nxt != mode_q);
    supp = {{(N_BUTTONS-1){chg}}, 1'b0};
  end

  // Idle counter; any activity or a protected mode keeps it at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      icnt     <= '0;
      lvl_prev <= '1;
    end else begin
      lvl_prev <= bus.btn_level;
      if (idle_clr || idle_to) begin
        icnt <= '0;
      end else if (tick && icnt != ILAST) begin
        icnt <= icnt + 1'b1;
      end
    end
  end

  // Registered mode and event strobes; a mode change masks buttons 1..N-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= HOME;
      mchg_q <= 1'b0;
      sp_q   <= '0;
      lp_q   <= '0;
      rp_q   <= '0;
    end else begin
      mode_q <= mode_nxt;
      mchg_q <= chg;
      sp_q   <= sn & ~supp;
      lp_q   <= ln & ~supp;
      rp_q   <= rn & ~supp;
    end
  end

  assign bus.mode         = mode_q;
  assign bus.mode_changed = mchg_q;
  assign bus.short_press  = sp_q;
  assign bus.long_press   = lp_q;
  assign bus.repeat_press = rp_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: table of presses plus hand-written corner cases.
// Expected events are queued at drive time and matched at negedge.
module tb_mode_ctrl;

  localparam int L = 8;
  localparam int R = 3;
  localparam int T = 50;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mode_ctrl_if #(.N_BUTTONS(4), .MW(2)) bus ();

  mode_ctrl #(
    .N_MODES         (4),
    .N_BUTTONS       (4),
    .CLK_HZ          (1000),
    .LONG_PRESS_MS   (L),
    .REPEAT_MS       (R),
    .IDLE_TIMEOUT_MS (T)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       mc;
    logic [3:0] sp;
    logic [3:0] lp;
    logic [3:0] rp;
  } ev_t;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic       lng;
    int         nrep;
    logic [1:0] mode;
    logic       mc;
  } vec_t;

  ev_t exp_q[$];
  ev_t want;

  always @(negedge clock) begin
    if (reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_event at cyc=%0d want cyc=%0d",
                 cyc, exp_q[0].cyc);
        want = exp_q.pop_front();
      end
      if (bus.mode_changed || (|bus.short_press) ||
          (|bus.long_press) || (|bus.repeat_press)) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d mode=%0d mc=%b sp=%b lp=%b rp=%b",
                   cyc, bus.mode, bus.mode_changed, bus.short_press,
                   bus.long_press, bus.repeat_press);
        end else begin
          want = exp_q.pop_front();
          if (want.cyc != cyc || want.mode != bus.mode ||
              want.mc != bus.mode_changed ||
              want.sp != bus.short_press ||
              want.lp != bus.long_press ||
              want.rp != bus.repeat_press) begin
            fails++;
            $display("FAIL event got cyc=%0d mode=%0d mc=%b sp=%b lp=%b rp=%b want cyc=%0d mode=%0d mc=%b sp=%b lp=%b rp=%b",
                     cyc, bus.mode, bus.mode_changed, bus.short_press,
                     bus.long_press, bus.repeat_press, want.cyc,
                     want.mode, want.mc, want.sp, want.lp, want.rp);
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void push(int c, logic [1:0] m, logic mc,
                               logic [3:0] s, logic [3:0] l,
                               logic [3:0] r);
    ev_t e;
    e.cyc  = c;
    e.mode = m;
    e.mc   = mc;
    e.sp   = s;
    e.lp   = l;
    e.rp   = r;
    exp_q.push_back(e);
  endfunction

  // Level rises before edge k+1, is sampled high through edge k+hold.
  task automatic run_row(vec_t v);
    int k;
    k = cyc;
    if (v.lng) begin
      push(k + 1 + L, v.mode, v.mc, 4'b0, v.btn, 4'b0);
      for (int j = 1; j <= v.nrep; j++)
        push(k + 1 + L + R * j, v.mode, 1'b0, 4'b0, 4'b0, v.btn);
    end else begin
      push(k + v.hold + 1, v.mode, v.mc, v.btn, 4'b0, 4'b0);
    end
    bus.btn_level = bus.btn_level | v.btn;
    step(v.hold);
    bus.btn_level = bus.btn_level & ~v.btn;
    step(4);
    chk("row_mode", int'(bus.mode), int'(v.mode));
  endtask

  initial begin
    vec_t tbl[18];
    int   kr;
    int   kh;
    tbl[0]  = '{4'b0010,  3, 1'b0, 0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0001,  2, 1'b0, 0, 2'd1, 1'b1};
    tbl[2]  = '{4'b0001,  2, 1'b0, 0, 2'd2, 1'b1};
    tbl[3]  = '{4'b0001,  2, 1'b0, 0, 2'd3, 1'b1};
    tbl[4]  = '{4'b0001,  2, 1'b0, 0, 2'd0, 1'b1};
    tbl[5]  = '{4'b0110,  3, 1'b0, 0, 2'd0, 1'b0};
    tbl[6]  = '{4'b0001,  8, 1'b0, 0, 2'd1, 1'b1};
    tbl[7]  = '{4'b0010,  9, 1'b1, 0, 2'd1, 1'b0};
    tbl[8]  = '{4'b0010, 21, 1'b1, 4, 2'd1, 1'b0};
    tbl[9]  = '{4'b0001,  2, 1'b0, 0, 2'd2, 1'b1};
    tbl[10] = '{4'b0001,  2, 1'b0, 0, 2'd3, 1'b1};
    tbl[11] = '{4'b0001, 10, 1'b1, 0, 2'd0, 1'b1};
    tbl[12] = '{4'b0001, 10, 1'b1, 0, 2'd0, 1'b0};
    tbl[13] = '{4'b1000, 12, 1'b1, 1, 2'd0, 1'b0};
    tbl[14] = '{4'b0001,  2, 1'b0, 0, 2'd1, 1'b1};
    tbl[15] = '{4'b0001,  2, 1'b0, 0, 2'd2, 1'b1};
    tbl[16] = '{4'b0001,  2, 1'b0, 0, 2'd1, 1'b1};
    tbl[17] = '{4'b0001,  2, 1'b0, 0, 2'd2, 1'b1};

    bus.btn_level = 4'b0010;
    bus.hold_mode = 1'b0;
    reset = 1'b0;
    step(3);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_mc", int'(bus.mode_changed), 0);
    chk("rst_strobes", int'({bus.short_press, bus.long_press,
                             bus.repeat_press}), 0);
    reset = 1'b1;
    step(5);
    bus.btn_level = 4'b0000;
    step(5);

    for (int i = 0; i < 14; i++) run_row(tbl[i]);

    run_row(tbl[14]);
    bus.btn_level[2] = 1'b1;
    step(2);
    run_row(tbl[15]);
    step(12);
    bus.btn_level[2] = 1'b0;
    kr = cyc;
    push(kr + T + 1, 2'd0, 1'b1, 4'b0, 4'b0, 4'b0);
    step(2);
    chk("supp_mode", int'(bus.mode), 2);
    step(T + 10);
    chk("idle_mode", int'(bus.mode), 0);

    run_row(tbl[16]);
    run_row(tbl[17]);
    bus.hold_mode = 1'b1;
    step(100);
    chk("hold_mode_kept", int'(bus.mode), 2);
    bus.hold_mode = 1'b0;
    kh = cyc;
    push(kh + T, 2'd0, 1'b1, 4'b0, 4'b0, 4'b0);
    step(T - 1);
    chk("idle_pre", int'(bus.mode), 2);
    step(1);
    chk("idle_post", int'(bus.mode), 0);
    step(5);
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Parametrised successor to the single-button mode counter in the clock top level.
- Sits between the per-button antidrebezg instances and the function blocks (setup, timer, stopwatch, display); consumes debounced button levels.
- Produces the current mode, classified button events (short, long, auto-repeat) and mode-change strobes.
- Adds long-press "home" and automatic idle return to mode 0 (clock display).

Parameters:
- N_MODES, 4, number of modes; mode 0 = clock display; must be 2..16.
- N_BUTTONS, 4, number of buttons; button 0 is the mode button.
- CLK_HZ, 50_000_000, clock frequency; sets the 1 ms prescaler (CLK_HZ/1000 cycles).
- LONG_PRESS_MS, 1000, hold time that classifies a long press; >= 2.
- REPEAT_MS, 200, auto-repeat period while held after a long press; 0 disables repeat.
- IDLE_TIMEOUT_MS, 30000, inactivity time before automatic return to mode 0; 0 disables.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_level  in  N_BUTTONS  debounced button levels, 1 = pressed, synchronous to clock.
- hold_mode  in  1  1 = inhibit idle return (stopwatch running / timer armed).
- mode  out  MW=$clog2(N_MODES)  current mode.
- mode_changed  out  1  one-cycle strobe when mode changes.
- short_press  out  N_BUTTONS  one-cycle strobe per button on short release.
- long_press  out  N_BUTTONS  one-cycle strobe when the hold reaches LONG_PRESS_MS.
- repeat_press  out  N_BUTTONS  one-cycle strobes during a continued hold after a long press.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: mode=0; all strobes 0; all counters 0; classifiers IDLE.
- Reset values: previous-level register = all ones, so a button held through reset gives no event until it is released and pressed again.
- ms tick: prescaler counts 0..CLK_HZ/1000-1 and pulses tick on wrap. If CLK_HZ/1000 == 1, tick is high every cycle.
- Per-button classifier states: IDLE, PRESSED, HELD, SUPPRESS.
- IDLE -> PRESSED on a rising edge of btn_level; hold counter cleared.
- PRESSED: counter increments on each tick.
- PRESSED, falling edge with counter < LONG_PRESS_MS -> short_press strobe on the next cycle; -> IDLE.
- PRESSED, counter reaches LONG_PRESS_MS -> long_press strobe on the next cycle; -> HELD; repeat counter cleared.
- HELD: when REPEAT_MS > 0, repeat_press strobes every REPEAT_MS ticks. Release -> IDLE with no short strobe.
- SUPPRESS: no strobes; -> IDLE on release.
- Latency: every strobe is registered, one cycle after the sampled edge or terminal count. With a tick every cycle, a press sampled at cycle t gives long_press at t+LONG_PRESS_MS.
- Mode button short press: mode <= (mode == N_MODES-1) ? 0 : mode+1, with wrap-around.
- Mode button long press: if mode != 0, mode <= 0. No mode change if already 0.
- mode_changed asserts in the same cycle the new mode value first appears, only when the value actually differs.
- Mode button strobes are also output on bit 0 of the strobe buses.
- On any mode change, buttons 1..N-1 in PRESSED or HELD go to SUPPRESS, so no stray event leaks into the new mode.
- Idle counter clears on any btn_level edge, on any mode change, while hold_mode=1, and while mode == 0. Otherwise it increments on tick.
- Idle timeout: when the idle counter reaches IDLE_TIMEOUT_MS, mode <= 0 and mode_changed pulses; buttons 1..N-1 are handled as for any mode change.
- Simultaneous idle timeout and mode-button event in the same cycle: the button event wins, because any edge clears the idle counter.
- Several buttons may be active concurrently; classifiers are independent.
- Width rules: hold, repeat and idle counters are sized with $clog2(max+1) and saturate, never wrap.

Decomposition:
- Package chasy_pkg holds MS_DIV(CLK_HZ), the mode enum constants (MODE_CLOCK=0, MODE_SETUP=1, MODE_TIMER=2, MODE_STOPWATCH=3) and the classifier state enum.
- Sub-module press_classifier: one instance per button via generate. Inputs: tick, level, suppress. Outputs: short, long and repeat strobes.
- mode_ctrl holds the prescaler, the mode register and the idle counter.

Test Plan:
- Sim parameters: CLK_HZ=1000, LONG_PRESS_MS=8, REPEAT_MS=3, IDLE_TIMEOUT_MS=50.
- Reset: reset=0 with btn_level=4'b0010 held -> all outputs 0 and mode=0. Release reset with btn1 still held, then release btn1 -> no strobes. Press btn1 again for 3 cycles -> short_press[1] once.
- Mode cycling: four 2-cycle presses of btn0 -> mode 1,2,3,0, one mode_changed strobe each. The 3->0 step shows wrap-around.
- Long press and repeat: hold btn1 20 cycles in mode 1 -> long_press[1] at press+8; repeat_press[1] at +11, +14, +17, +20; no short_press on release.
- Home via long press: in mode 3, hold btn0 10 cycles -> mode=0 at press+8 with mode_changed. Repeat in mode 0 -> no mode_changed.
- Suppression: hold btn2 in mode 1, short-press btn0 -> mode 2. Then release btn2 -> no short or long strobe on bit 2.
- Idle return: mode 2, no activity -> mode=0 after 50 cycles. Repeat with hold_mode=1 for 100 cycles -> mode stays 2. Drop hold_mode -> mode=0 50 cycles later.
